// File: rtl/bluetooth_pkg.sv
// -----------------------------------------------------------------------------
// bluetooth_pkg
// Shared constants and types for the Bluetooth UART link. The transmitter and
// the receiver both take their default clock and baud settings from here so the
// two ends of the link always agree on the bit period.
//   CLK_HZ       : default system clock frequency in Hz
//   BAUD         : default serial bit rate
//   BIT_DIV      : clocks per serial bit at the defaults (integer division)
//   calc_bit_div : clocks per serial bit for any clock/baud pair
//   tx_state_t   : transmitter FSM state encoding
// -----------------------------------------------------------------------------
package bluetooth_pkg;

   localparam int CLK_HZ  = 100_000_000;
   localparam int BAUD    = 9_600;
   localparam int BIT_DIV = CLK_HZ / BAUD;

   function automatic int calc_bit_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// Byte FIFO that buffers bytes waiting to be serialised. The head entry is
// presented combinationally on o_rdata; o_pop consumes it. Pointers wrap
// naturally because DEPTH is a power of two.
//   clk, rst : system clock, synchronous active-high reset
//   i_push   : write i_wdata at the tail (ignored when full)
//   i_wdata  : byte to write
//   i_pop    : consume the head entry (ignored when empty)
//   o_rdata  : current head entry
//   o_full   : o_count == DEPTH
//   o_empty  : o_count == 0
//   o_count  : number of stored bytes
// -----------------------------------------------------------------------------
module tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [7:0]               i_wdata,
   input  logic                     i_pop,
   output logic [7:0]               o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; only the pointers and
   // count define what is valid, and leaving it out lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/bluetooth_tx.sv
// -----------------------------------------------------------------------------
// bluetooth_tx
// Buffered 8N1 UART transmitter feeding a serial Bluetooth module. Bytes are
// accepted through a valid/ready handshake into tx_fifo, then shifted out LSB
// first: one start bit (0), eight data bits, one stop bit (1), each held for
// BIT_DIV clocks. Buffered frames are sent back to back with no idle gap.
//   clk        : system clock
//   rst        : synchronous active-high reset; aborts any frame, empties FIFO
//   tx_data    : byte to send, taken when tx_valid && tx_ready at a posedge
//   tx_valid   : producer has a byte on tx_data
//   tx_ready   : FIFO has room (registered count only, no combinational path)
//   TxD        : registered serial output, idle high
//   busy       : frame in progress or bytes waiting
//   fifo_count : bytes buffered and not yet started
// -----------------------------------------------------------------------------
module bluetooth_tx
   import bluetooth_pkg::*;
#(
   parameter int CLK_HZ     = bluetooth_pkg::CLK_HZ,
   parameter int BAUD       = bluetooth_pkg::BAUD,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          TxD,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int              BIT_DIV = calc_bit_div(CLK_HZ, BAUD);
   // One spare count value keeps the width sane even when BIT_DIV is 1.
   localparam int              CNT_W   = $clog2(BIT_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_DIV - 1);

   tx_state_t        r_state;
   tx_state_t        w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [7:0]       r_shift;
   logic             r_txd;
   logic             w_txd_next;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_tick;
   logic [7:0]       w_head;

   // Ready comes straight from the registered count, so a full FIFO refuses a
   // write even in a cycle where the FSM pops.
   assign tx_ready = ~w_full;
   assign w_push   = tx_valid & ~w_full;
   assign w_tick   = (r_cnt == CNT_MAX);
   assign TxD      = r_txd;
   assign busy     = (r_state != IDLE) || (fifo_count != '0);

   tx_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (tx_data),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_txd_next   = 1'b1;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = START;
            end
         end
         START: begin
            w_txd_next = 1'b0;
            if (w_tick) w_state_next = DATA;
         end
         DATA: begin
            w_txd_next = r_shift[r_idx];
            if (w_tick && (r_idx == 3'd7)) w_state_next = STOP;
         end
         STOP: begin
            // Chain straight into the next start bit when bytes are waiting.
            if (w_tick) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = START;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // TxD is the registered image of the current state's line level, so it
   // trails the state by one clock and every level lasts exactly BIT_DIV clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_txd   <= 1'b1;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_txd <= w_txd_next;
         if (w_pop) begin
            r_shift <= w_head;
            r_cnt   <= '0;
            r_idx   <= '0;
         end else if (r_state != IDLE) begin
            if (w_tick) begin
               r_cnt <= '0;
               if (r_state == DATA) r_idx <= r_idx + 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bluetooth_tx.sv
// -----------------------------------------------------------------------------
// tb_bluetooth_tx
// Directed bench for bluetooth_tx. A short bit period (10 clocks) keeps frames
// small. A mid-bit sampling receiver model decodes TxD into a byte queue.
// -----------------------------------------------------------------------------
module tb_bluetooth_tx;

   localparam int CLK_HZ = 1000;
   localparam int BAUD   = 100;
   localparam int BD     = CLK_HZ / BAUD;
   localparam int DEPTH  = 4;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          TxD;
   logic          busy;
   logic [CW-1:0] fifo_count;

   int vec  = 0;
   int miss = 0;

   always #5 clk = ~clk;

   bluetooth_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .TxD        (TxD),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   // Receiver model: detects a falling edge, then samples mid-bit.
   bit         rx_on   = 1'b0;
   int         rx_t    = 0;
   int         rx_ferr = 0;
   logic [7:0] rx_sh   = 8'h00;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         rx_on <= 1'b0;
      end else if (!rx_on) begin
         if (TxD === 1'b0) begin
            rx_on <= 1'b1;
            rx_t  <= 1;
         end
      end else begin
         rx_t <= rx_t + 1;
         if ((rx_t >= BD / 2) && (((rx_t - BD / 2) % BD) == 0)) begin
            if ((rx_t - BD / 2) / BD == 0) begin
               if (TxD !== 1'b0) rx_ferr <= rx_ferr + 1;
            end else if ((rx_t - BD / 2) / BD <= 8) begin
               rx_sh <= {TxD, rx_sh[7:1]};
            end else begin
               if (TxD !== 1'b1) rx_ferr <= rx_ferr + 1;
               rx_q.push_back(rx_sh);
               rx_on <= 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_fall(input string name, input int limit);
      bit found;
      found = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (TxD === 1'b0) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      vec++;
      if (found !== 1'b1) begin
         miss++;
         $display("FAIL %s: TxD never fell within %0d clocks", name, limit);
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      bit found;
      found = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (busy === 1'b0) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      vec++;
      if (found !== 1'b1) begin
         miss++;
         $display("FAIL %s: busy still high after %0d clocks", name, limit);
      end
   endtask

   // Current sample must be the first clock of the start bit; returns one
   // clock past the end of the stop bit.
   task automatic check_frame(input string name, input logic [7:0] b);
      logic [9:0] bits;
      int         bad;
      logic       got;
      bits = {1'b1, b, 1'b0};
      bad  = -1;
      got  = 1'b0;
      for (int j = 0; j < 10 * BD; j++) begin
         if ((TxD !== bits[j / BD]) && (bad < 0)) begin
            bad = j;
            got = TxD;
         end
         tick();
      end
      vec++;
      if (bad >= 0) begin
         miss++;
         $display("FAIL %s: TxD=%b at clock %0d of frame, expected %b",
                  name, got, bad, bits[bad / BD]);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tick(3);
      vec++; if (TxD !== 1'b1)      begin miss++; $display("FAIL reset_txd: got %b want 1", TxD); end
      vec++; if (fifo_count !== '0) begin miss++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      vec++; if (busy !== 1'b0)     begin miss++; $display("FAIL reset_busy: got %b want 0", busy); end
      vec++; if (tx_ready !== 1'b1) begin miss++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
      rst = 1'b0;
      tick(2);
      vec++; if (TxD !== 1'b1)      begin miss++; $display("FAIL idle_txd: got %b want 1", TxD); end
      vec++; if (busy !== 1'b0)     begin miss++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single_byte();
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      tick();                                   // handshake edge E0
      tx_valid = 1'b0;
      vec++; if (fifo_count !== CW'(1)) begin miss++; $display("FAIL single_count_e0: got %0d want 1", fifo_count); end
      vec++; if (busy !== 1'b1)         begin miss++; $display("FAIL single_busy_e0: got %b want 1", busy); end
      vec++; if (TxD !== 1'b1)          begin miss++; $display("FAIL single_txd_e0: got %b want 1", TxD); end
      tick();                                   // E0+1: popped, line still high
      vec++; if (TxD !== 1'b1)          begin miss++; $display("FAIL single_txd_e1: got %b want 1", TxD); end
      vec++; if (fifo_count !== '0)     begin miss++; $display("FAIL single_count_e1: got %0d want 0", fifo_count); end
      tick();                                   // E0+2: start bit
      vec++; if (TxD !== 1'b0)          begin miss++; $display("FAIL single_latency: got %b want 0", TxD); end
      check_frame("single_55_frame", 8'h55);
      vec++; if (busy !== 1'b0)         begin miss++; $display("FAIL single_busy_end: got %b want 0", busy); end
      vec++; if (TxD !== 1'b1)          begin miss++; $display("FAIL single_txd_end: got %b want 1", TxD); end
   endtask

   task automatic test_loopback();
      int         base;
      int         ferr0;
      logic [7:0] got;
      base  = rx_q.size();
      ferr0 = rx_ferr;
      tx_valid = 1'b1;
      tx_data  = 8'hA3;
      tick();
      tx_data  = 8'h0F;
      tick();
      tx_valid = 1'b0;
      wait_idle("loopback_idle", 25 * BD);
      tick(2);
      vec++; if (rx_q.size() !== base + 2) begin miss++; $display("FAIL loopback_count: got %0d want %0d", rx_q.size(), base + 2); end
      got = (rx_q.size() > base) ? rx_q[base] : 8'hxx;
      vec++; if (got !== 8'hA3) begin miss++; $display("FAIL loopback_byte0: got %h want a3", got); end
      got = (rx_q.size() > base + 1) ? rx_q[base + 1] : 8'hxx;
      vec++; if (got !== 8'h0F) begin miss++; $display("FAIL loopback_byte1: got %h want 0f", got); end
      vec++; if (rx_ferr !== ferr0) begin miss++; $display("FAIL loopback_framing: got %0d errors want 0", rx_ferr - ferr0); end
   endtask

   task automatic test_back_to_back();
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      tick();
      tx_data  = 8'hC3;
      tick();
      tx_valid = 1'b0;
      wait_fall("b2b_start", 5);
      check_frame("b2b_frame0", 8'h3C);
      check_frame("b2b_frame1_zero_gap", 8'hC3);
      vec++; if (busy !== 1'b0) begin miss++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
      vec++; if (TxD !== 1'b1)  begin miss++; $display("FAIL b2b_txd_end: got %b want 1", TxD); end
   endtask

   task automatic test_overflow();
      int         base;
      logic [7:0] got;
      logic [7:0] want;
      base = rx_q.size();
      for (int i = 0; i < 6; i++) begin
         tx_data  = 8'(8'h11 + i);
         tx_valid = 1'b1;
         vec++;
         if (tx_ready !== (i < 5)) begin
            miss++;
            $display("FAIL overflow_ready_%0d: got %b want %b", i, tx_ready, (i < 5));
         end
         tick();
      end
      vec++; if (fifo_count !== CW'(4)) begin miss++; $display("FAIL overflow_count: got %0d want 4", fifo_count); end
      vec++; if (tx_ready !== 1'b0)     begin miss++; $display("FAIL overflow_ready_full: got %b want 0", tx_ready); end
      // Valid held high with changing data while full: nothing may be written.
      for (int i = 0; i < 5; i++) begin
         tx_data = 8'(8'h70 + i);
         tick();
         vec++;
         if (fifo_count !== CW'(4)) begin
            miss++;
            $display("FAIL full_hold_%0d: got count %0d want 4", i, fifo_count);
         end
      end
      tx_valid = 1'b0;
      wait_idle("overflow_drain", 6 * 10 * BD + 20);
      tick(2);
      vec++; if (rx_q.size() !== base + 5) begin miss++; $display("FAIL overflow_rx_count: got %0d want %0d", rx_q.size(), base + 5); end
      for (int i = 0; i < 5; i++) begin
         want = 8'(8'h11 + i);
         got  = (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx;
         vec++;
         if (got !== want) begin
            miss++;
            $display("FAIL overflow_order_%0d: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      int bad;
      base = rx_q.size();
      tx_valid = 1'b1;
      tx_data  = 8'h81; tick();
      tx_data  = 8'h42; tick();
      tx_data  = 8'h24; tick();
      tx_data  = 8'h18; tick();
      tx_valid = 1'b0;
      vec++; if (fifo_count !== CW'(3)) begin miss++; $display("FAIL midrst_count_pre: got %0d want 3", fifo_count); end
      tick(3 * BD);                             // well inside the data bits
      vec++; if (busy !== 1'b1) begin miss++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'hEE;
      tick();
      vec++; if (TxD !== 1'b1)      begin miss++; $display("FAIL midrst_txd: got %b want 1", TxD); end
      vec++; if (fifo_count !== '0) begin miss++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
      vec++; if (busy !== 1'b0)     begin miss++; $display("FAIL midrst_busy: got %b want 0", busy); end
      vec++; if (tx_ready !== 1'b1) begin miss++; $display("FAIL midrst_ready: got %b want 1", tx_ready); end
      tick();
      vec++; if (fifo_count !== '0) begin miss++; $display("FAIL midrst_push_ignored: got %0d want 0", fifo_count); end
      rst      = 1'b0;
      tx_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 12 * BD; i++) begin
         tick();
         if (TxD !== 1'b1) bad++;
      end
      vec++; if (bad !== 0)                begin miss++; $display("FAIL midrst_line_quiet: got %0d low clocks want 0", bad); end
      vec++; if (rx_q.size() !== base)     begin miss++; $display("FAIL midrst_no_frames: got %0d frames want 0", rx_q.size() - base); end
      vec++; if (busy !== 1'b0)            begin miss++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_loopback();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/bluetooth_tx.md
BLUETOOTH_TX -- requirements
Module: bluetooth_tx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9_600, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, byte buffer entries; power of two, at least 2.
REQ-004 clk  input  1  system clock; single clock domain; all logic on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 tx_data  input  8  byte to send, sampled when tx_valid and tx_ready are both high at a posedge.
REQ-007 tx_valid  input  1  producer has a byte on tx_data.
REQ-008 tx_ready  output  1  buffer can accept a byte this cycle.
REQ-009 TxD  output  1  serial line to the Bluetooth module; idle high; 8N1 framing, LSB first.
REQ-010 busy  output  1  frame in progress or buffer non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of buffered bytes not yet started.

Function
REQ-012 BIT_DIV SHALL equal CLK_HZ/BAUD with integer division (10416 at default parameters); every serial bit SHALL be held on TxD for exactly BIT_DIV clocks.
REQ-013 A handshake at a posedge SHALL write tx_data into the FIFO tail; tx_ready SHALL be high if and only if fifo_count < FIFO_DEPTH.
REQ-014 tx_ready SHALL NOT depend combinationally on tx_valid or on a same-cycle pop; a full FIFO refuses writes even when a pop occurs in that cycle.
REQ-015 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-016 IDLE: TxD=1. If the FIFO is non-empty, at the next posedge the FSM pops the head into the shift register, clears the bit counter and enters START.
REQ-017 START: TxD=0 for BIT_DIV clocks, then the FSM enters DATA with bit index 0.
REQ-018 DATA: TxD = shift-register bit[index] for BIT_DIV clocks per bit, for indices 0 through 7, then the FSM enters STOP.
REQ-019 STOP: TxD=1 for BIT_DIV clocks.
  - At the end of STOP, if the FIFO is non-empty, the FSM pops the next byte and enters START directly, with zero idle clocks between frames.
  - Otherwise the FSM enters IDLE.
REQ-020 TxD SHALL be a registered output with no glitches; a frame is exactly 10*BIT_DIV clocks long.
REQ-021 Latency: with the FSM in IDLE and the FIFO empty, a handshake at edge E0 SHALL cause TxD to fall at edge E0+2.
REQ-022 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
  - The pointers SHALL wrap modulo FIFO_DEPTH.
  - Data order SHALL be strictly FIFO.
REQ-023 busy SHALL equal (state != IDLE) OR (fifo_count != 0).
REQ-024 The bit counter SHALL be wide enough for BIT_DIV-1 and SHALL never overflow; tx_data is not sampled outside a handshake.

Reset
REQ-025 While rst is high at a posedge:
  - state becomes IDLE, TxD=1, busy=0, fifo_count=0, tx_ready=1;
  - FIFO pointers, bit counter, bit index and shift register are cleared.
REQ-026 A reset during an active frame SHALL abort the frame, drive TxD high from the following clock, and discard all buffered bytes; handshakes in reset cycles are ignored.

Structure
REQ-027 The package bluetooth_pkg SHALL hold CLK_HZ, BAUD, the BIT_DIV calculation and the tx state encoding (IDLE/START/DATA/STOP); the receiver shares the baud constants.
REQ-028 The FIFO SHALL be a separate sub-module, tx_fifo, with push/pop/full/empty/count ports; the FSM and shift register stay in bluetooth_tx.

Verification
REQ-029 Single byte 0x55 pushed from idle -> TxD = 0,1,0,1,0,1,0,1,0,1, each level exactly 10416 clocks; TxD falls 2 clocks after the handshake; busy drops after the stop bit.
REQ-030 Loopback into the existing Bluetooth receiver, sending 0xA3 then 0x0F -> receiver RxData shows 0xA3 then 0x0F.
REQ-031 Six pushes on consecutive clocks from idle with FIFO_DEPTH=4:
  - the first five are accepted;
  - fifo_count reaches 4 and tx_ready is low on the sixth;
  - all five bytes are transmitted in order.
REQ-032 Two buffered bytes -> the second start bit begins on the clock immediately after the first stop bit's 10416th clock (zero-gap frames).
REQ-033 rst asserted in the middle of DATA with 3 bytes buffered:
  - the next clock shows TxD=1, fifo_count=0, busy=0, tx_ready=1;
  - no further frames are sent.
REQ-034 tx_valid held high with tx_data changing while tx_ready is low -> no write occurs and fifo_count stays at 4.
